// File: rtl/serial_alu.sv
// Digit-serial ALU: consumes DIGIT bits per cycle, LSB first, with one carry register between digits.
// The result and flags update only on the edge that processes the final digit.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; outputs hold the last result
//   S_RUN  | processing digit cnt_q; busy high, start ignored
//   S_DONE | one cycle with done high; a start here is accepted at once
module serial_alu #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       control,
   output logic [WIDTH-1:0] out,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       ctl_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;

   logic [WIDTH-1:0] out_q;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q;
   logic             neg_q;

   logic             accept;
   logic             last_digit;
   logic             is_arith;
   logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_res;
   logic [DIGIT:0]   sum;

   assign accept     = start && (state_q != S_RUN);
   assign last_digit = (cnt_q == CW'(N - 1));

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_digit) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Operands shift right each cycle, so the current digit always sits in the low bits.
   assign a_dig    = a_q[DIGIT-1:0];
   assign b_dig    = b_q[DIGIT-1:0];
   assign b_eff    = b_dig ^ {DIGIT{ctl_q[0]}};
   assign is_arith = (ctl_q[2:1] == 2'b01);
   assign sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};

   always_comb begin
      dig_res = '0;
      case (ctl_q)
         3'd2, 3'd3: dig_res = sum[DIGIT-1:0];
         3'd4:       dig_res = a_dig & b_dig;
         3'd5:       dig_res = a_dig | b_dig;
         3'd6:       dig_res = ~(a_dig | b_dig);
         3'd7:       dig_res = a_dig ^ b_dig;
         default:    dig_res = '0;
      endcase
   end

   // Result fills from the top; after N digits the LSB digit has reached bit 0.
   assign shadow_d = (shadow_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
   assign carry_d  = is_arith ? sum[DIGIT] : carry_q;
   assign cout_d   = is_arith & sum[DIGIT];
   // Carry into the MSB recovered as a^b^s of that bit.
   assign ovf_d    = is_arith & (a_dig[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT]);

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         ctl_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         shadow_q <= '0;
         out_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= A;
         b_q     <= B;
         ctl_q   <= control;
         cnt_q   <= '0;
         carry_q <= control[0];
      end else if (state_q == S_RUN) begin
         a_q      <= a_q >> DIGIT;
         b_q      <= b_q >> DIGIT;
         shadow_q <= shadow_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_q + CW'(1);
         if (last_digit) begin
            out_q  <= shadow_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= (shadow_d == '0);
            neg_q  <= shadow_d[WIDTH-1];
         end
      end
   end

   assign out      = out_q;
   assign carryout = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign negative = neg_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance,
// driven one at a time and checked through a shared scoreboard.
module tb_serial_alu;

   typedef struct {
      int          id;
      logic [15:0] out;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
      int          acc;
      int          done_cyc;
   } item_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, out8;
   logic [2:0]  c8 = '0;
   logic        cout8, ovf8, zero8, neg8, busy8, done8;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, out16;
   logic [2:0]  c16 = '0;
   logic        cout16, ovf16, zero16, neg16, busy16, done16;

   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   item_t       sbq[$];
   logic [15:0] held_out[2];
   logic [3:0]  held_fl[2];

   serial_alu #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clock(clock), .reset(reset), .start(start8), .A(a8), .B(b8), .control(c8),
      .out(out8), .carryout(cout8), .overflow(ovf8), .zero(zero8), .negative(neg8),
      .busy(busy8), .done(done8)
   );

   serial_alu #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clock(clock), .reset(reset), .start(start16), .A(a16), .B(b16), .control(c16),
      .out(out16), .carryout(cout16), .overflow(ovf16), .zero(zero16), .negative(neg16),
      .busy(busy16), .done(done16)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic at the given width.
   function automatic item_t model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                   input logic [2:0] c);
      item_t       it;
      logic [15:0] mask, a, b, r;
      logic [16:0] full;
      bit          co, ov;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      a = ai & mask;
      b = bi & mask;
      r = '0; co = 0; ov = 0;
      case (c)
         3'd2: begin
            full = {1'b0, a} + {1'b0, b};
            r = full[15:0] & mask; co = full[w];
            ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
         end
         3'd3: begin
            full = {1'b0, a} + {1'b0, ~b & mask} + 17'd1;
            r = full[15:0] & mask; co = full[w];
            ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = ~(a | b) & mask;
         3'd7: r = a ^ b;
         default: r = '0;
      endcase
      it.out = r; it.cout = co; it.ovf = ov; it.zero = (r == 0); it.neg = r[w-1];
      it.id = 0; it.acc = 0; it.done_cyc = 0;
      return it;
   endfunction

   // Monitor: pops an expectation whenever a DUT raises done.
   always @(negedge clock) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            logic [15:0] o;
            logic [3:0]  fl;
            logic        bz, dn;
            bit          front, eb;
            item_t       it;
            o  = d ? out16 : {8'h00, out8};
            fl = d ? {cout16, ovf16, zero16, neg16} : {cout8, ovf8, zero8, neg8};
            bz = d ? busy16 : busy8;
            dn = d ? done16 : done8;
            front = (sbq.size() > 0) && (sbq[0].id == d);
            eb = front && (cyc >= sbq[0].acc) && (cyc < sbq[0].done_cyc);
            chk("busy", d, 32'(bz), 32'(eb));
            if (dn) begin
               if (!front) begin
                  checks++; fails++;
                  $display("FAIL unexpected_done dut%0d cyc=%0d: got done=1 expected done=0", d, cyc);
               end else begin
                  it = sbq.pop_front();
                  chk("result", d, {12'h0, o, fl}, {12'h0, it.out, it.cout, it.ovf, it.zero, it.neg});
                  chk("latency", d, cyc, it.done_cyc);
                  held_out[d] = it.out;
                  held_fl[d]  = {it.cout, it.ovf, it.zero, it.neg};
               end
            end else begin
               if (front && cyc >= sbq[0].done_cyc) begin
                  checks++; fails++;
                  $display("FAIL missing_done dut%0d cyc=%0d: got done=0 expected done=1", d, cyc);
                  void'(sbq.pop_front());
               end
               chk("hold", d, {12'h0, o, fl}, {12'h0, held_out[d], held_fl[d]});
            end
         end
      end
   end

   task automatic drive(input int id, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] c);
      if (id == 0) begin
         start8 = s; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
      end else begin
         start16 = s; a16 = a; b16 = b; c16 = c;
      end
   endtask

   task automatic idle(input int n);
      start8 = 1'b0;
      start16 = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk_zero_outputs();
      chk("reset_state", 0, 32'({out8, cout8, ovf8, zero8, neg8, busy8, done8}), 32'd0);
      chk("reset_state", 1, 32'({out16, cout16, ovf16, zero16, neg16, busy16, done16}), 32'd0);
   endtask

   // Called just after a posedge; the next edge is the reset edge.
   task automatic do_reset(input bit with_start);
      reset = 1'b1;
      start8 = with_start; a8 = 8'h12; b8 = 8'h34; c8 = 3'd2;
      start16 = 1'b0;
      sbq.delete();
      for (int d = 0; d < 2; d++) begin
         held_out[d] = '0;
         held_fl[d]  = '0;
      end
      @(posedge clock);
      @(negedge clock);
      chk_zero_outputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      start8 = 1'b0;
   endtask

   // Called just after a posedge. Returns just after the completion edge (inside DONE).
   task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] c, input bit noise, input int abort_after);
      int    n;
      item_t it;
      n = (id == 1) ? 4 : 8;
      it = model((id == 1) ? 16 : 8, a, b, c);
      it.id = id;
      it.acc = cyc + 1;
      it.done_cyc = cyc + 1 + n;
      sbq.push_back(it);
      drive(id, 1'b1, a, b, c);
      @(posedge clock);
      #1;
      drive(id, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
         drive(id, noise && (k == 0), 16'($urandom), 16'($urandom), 3'($urandom));
         if (abort_after != 0 && k + 1 == abort_after) begin
            do_reset(1'b0);
            return;
         end
      end
      drive(id, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
   endtask

   initial begin
      int t;
      held_out[0] = '0; held_out[1] = '0;
      held_fl[0]  = '0; held_fl[1]  = '0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_zero_outputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle(2);

      run_op(0, 16'h7F, 16'h01, 3'd2, 0, 0); idle(1);
      run_op(0, 16'h05, 16'h05, 3'd3, 0, 0); idle(1);
      run_op(0, 16'h00, 16'h01, 3'd3, 0, 0); idle(1);
      run_op(0, 16'h80, 16'h01, 3'd3, 0, 0); idle(1);
      run_op(0, 16'hF0, 16'h0F, 3'd6, 0, 0); idle(1);
      run_op(0, 16'hAA, 16'hFF, 3'd7, 0, 0); idle(1);
      run_op(0, 16'hC3, 16'h0F, 3'd4, 0, 0); idle(1);
      run_op(0, 16'h10, 16'h01, 3'd5, 0, 0); idle(1);
      for (int c = 4; c < 8; c++) begin
         run_op(0, 16'hFF, 16'hFF, 3'(c), 0, 0);
      end
      idle(1);
      run_op(0, 16'h5A, 16'h33, 3'd0, 0, 0); idle(1);
      run_op(0, 16'h5A, 16'h33, 3'd1, 0, 0); idle(1);

      // Mid-RUN start ignored, then back-to-back issue from the DONE cycle.
      run_op(0, 16'h3C, 16'h21, 3'd2, 1, 0);
      run_op(0, 16'h01, 16'h02, 3'd3, 1, 0);
      run_op(0, 16'hE7, 16'h19, 3'd7, 0, 0);
      idle(2);

      // Reset during RUN cycle 3, then reset colliding with start.
      run_op(0, 16'h44, 16'h55, 3'd2, 0, 2);
      idle(1);
      run_op(0, 16'h12, 16'h34, 3'd2, 0, 0); idle(1);
      do_reset(1'b1);
      idle(1);

      run_op(1, 16'hFFFF, 16'h0001, 3'd2, 0, 0); idle(1);
      run_op(1, 16'h7FFF, 16'h0001, 3'd2, 1, 0);
      run_op(1, 16'h1234, 16'h4321, 3'd3, 0, 0); idle(1);

      for (int i = 0; i < 40; i++) begin
         run_op((i % 4 == 3) ? 1 : 0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 0);
         idle($urandom_range(0, 2));
      end

      t = 0;
      while (sbq.size() > 0 && t < 50) begin
         @(posedge clock);
         t++;
      end
      idle(2);
      chk("drain", 0, 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
Multi-cycle, parametrised-width ALU that processes DIGIT bits of the operands per clock, LSB first, with one carry register between digits. It uses the 3-bit control encoding of the single-bit ALU slice and adds operand latching, a start/busy/done handshake and registered condition flags (carry, overflow, zero, negative). It serves area-constrained datapaths that can trade latency for a narrow adder.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 1, bits processed per RUN cycle; N = WIDTH/DIGIT RUN cycles per operation

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled on the clock edge when state != RUN
A  input  WIDTH  operand A; latched when start is accepted
B  input  WIDTH  operand B; latched when start is accepted
control  input  3  2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR; 0/1 reserved; latched with operands
out  output  WIDTH  result register
carryout  output  1  final carry of ADD/SUB; 0 for logic ops
overflow  output  1  signed overflow of ADD/SUB; 0 for logic ops
zero  output  1  out == 0
negative  output  1  out[WIDTH-1]
busy  output  1  high while state == RUN
done  output  1  one-cycle pulse when a new result and flags appear

Behaviour:
- Clock and reset: one clock (clock). reset is synchronous and active-high.
- Reset values: state IDLE; out=0, carryout=0, overflow=0, zero=0, negative=0, busy=0, done=0, digit counter=0, carry register=0.
- When reset is high it overrides everything, including start on the same edge and an operation in progress. There is no partial completion, and no done pulse follows.
- States are IDLE, RUN and DONE.
- IDLE: if start=1, latch A, B and control; counter=0; carry register = control[0] (1 for SUB); go to RUN. Otherwise stay in IDLE.
- RUN (busy=1): on each edge, process digit k = counter, i.e. bits [k*DIGIT +: DIGIT].
  - Arithmetic (control=01x): sum = A_d + (B_d XOR {DIGIT{control[0]}}) + carry. Write the DIGIT sum bits into the shadow result and update the carry register.
  - Logic (control=1xx): AND / OR / NOR / XOR per bit on A_d and B_d (no B inversion). The carry register is unused.
  - Reserved control (0 or 1): the digit result is 0.
  - start is ignored in RUN.
  - After digit N-1 is processed, go to DONE.
- Completion, on the edge that processes the last digit:
  - out ← shadow result.
  - carryout ← final carry for ADD/SUB; 0 otherwise.
  - overflow ← (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1) for ADD/SUB; 0 otherwise.
  - zero and negative are computed from the new out.
  - done=1 for that cycle only; busy=0.
- DONE: lasts exactly one cycle. If start=1 it behaves as IDLE-accept (back-to-back operation, no bubble). Otherwise it goes to IDLE.
- Latency: with the start-accept edge E0, done is high in the cycle following edge E0+N. Issue interval is N+1 cycles.
- out and all flags hold their previous values for the whole of RUN. They change only on the completion edge or on reset.
- SUB carry convention: carryout=1 means no borrow (A >= B unsigned).
- Operand or control changes after the accept edge have no effect on the operation in flight.

Test Plan:
1. WIDTH=8, DIGIT=1: ADD A=8'h7F, B=8'h01 -> out=8'h80, overflow=1, negative=1, carryout=0, zero=0. done pulses exactly 8 cycles after the accept edge; busy is high for those 8 cycles.
2. WIDTH=8: SUB 8'h05-8'h05 -> out=8'h00, zero=1, carryout=1, overflow=0. Then SUB 8'h00-8'h01 -> out=8'hFF, carryout=0, negative=1, overflow=0. Then SUB 8'h80-8'h01 -> out=8'h7F, overflow=1.
3. WIDTH=8, logic ops:
   - NOR F0/0F -> 8'h00, zero=1.
   - XOR AA/FF -> 8'h55.
   - AND C3/0F -> 8'h03.
   - OR 10/01 -> 8'h11.
   - Logic ops also use A=8'hFF, B=8'hFF to check carryout=0 and overflow=0.
   - Reserved control=0 -> out=8'h00.
4. Handshake:
   - start pulses mid-RUN with different operands -> ignored; the original result is delivered.
   - start held high in the DONE cycle -> the second operation is accepted with no idle cycle.
   - out stays at the prior result throughout the second RUN.
5. Reset: assert reset at RUN cycle 3 of an ADD -> on the next edge all outputs are 0 and busy=0, with no done pulse. A following ADD 8'h12+8'h34 completes with out=8'h46.
6. WIDTH=16, DIGIT=4: ADD 16'hFFFF+16'h0001 -> out=16'h0000, carryout=1, zero=1, overflow=0. done arrives 4 cycles after the accept edge.
